// File: rtl/imem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_responder                                             |
// | Description : Single-outstanding instruction memory responder with a     |
// |               programmable fixed read latency, redirect flush and a      |
// |               side-band program-load write port.                         |
// |               Optional feature macro: IMEM_ALIGN_CHECK_EN (misaligned    |
// |               fetches return a NOP with resp_err set).                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module imem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_instr,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  resp_err,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-3:0] prog_addr,
    input  logic [31:0]           prog_wdata
);

    localparam int          c_DEPTH    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0]  c_CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_WAIT     = 2'd1;
    localparam logic [1:0]  c_RESP     = 2'd2;

    logic [31:0]           r_mem [c_DEPTH];
    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_instr;
    logic                  r_resp_err;

    logic [31:0]           w_rd_word;
    logic                  w_misalign;
    logic [31:0]           w_rd_instr;

    // Array is never reset; program load may happen in any FSM state.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    // Sampled before the same-edge write lands, so a collision returns old data.
    assign w_rd_word = r_mem[r_addr[ADDR_WIDTH-1:2]];

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_misalign = (r_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_rd_instr = w_misalign ? c_NOP : w_rd_word;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_instr <= 32'd0;
            r_resp_err   <= 1'b0;
        end else if (flush) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_addr      <= req_addr;
                        r_cnt       <= c_CNT_LOAD;
                        r_req_ready <= 1'b0;
                        r_state     <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_instr <= w_rd_instr;
                        r_resp_err   <= w_misalign;
                        r_resp_valid <= 1'b1;
                        r_state      <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    // Ready returns only on the following cycle: no accept on the consume edge.
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= c_IDLE;
                    end
                end
                default: begin
                    r_state      <= c_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid & ~flush;
    assign resp_instr = r_resp_instr;
    assign resp_addr  = r_addr;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the byte-address width; the array holds 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 1, the cycles from request accept to response valid; legal range 1..15.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, fetch request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when both req_valid and req_ready are high.
REQ-007 SHALL have port req_addr, input, ADDR_WIDTH, byte address of the instruction.
REQ-008 SHALL have port flush, input, 1, redirect cancel of any outstanding request or response.
REQ-009 SHALL have port resp_valid, output, 1, instruction word available.
REQ-010 SHALL have port resp_ready, input, 1, consumer takes the response.
REQ-011 SHALL have port resp_instr, output, 32, instruction word.
REQ-012 SHALL have port resp_addr, output, ADDR_WIDTH, address echoed with the response.
REQ-013 SHALL have port resp_err, output, 1, misaligned-address error flag.
REQ-014 SHALL have port prog_we, input, 1, program-load write strobe.
REQ-015 SHALL have port prog_addr, input, ADDR_WIDTH-2, word address for the program load.
REQ-016 SHALL have port prog_wdata, input, 32, word to write.

Function
REQ-017 SHALL implement a 3-state FSM with states IDLE, WAIT and RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE, so at most one request is outstanding.
REQ-019 On accept, SHALL latch req_addr, load the latency counter with LATENCY-1, and go to WAIT.
REQ-020 In WAIT, SHALL decrement the counter each cycle; when the counter is 0, SHALL read array[addr[ADDR_WIDTH-1:2]] into the response register and go to RESP.
REQ-021 Under REQ-019 and REQ-020, resp_valid SHALL first assert exactly LATENCY cycles after the accept edge.
REQ-022 In RESP, resp_valid=1 and resp_instr, resp_addr and resp_err SHALL hold stable until resp_valid and resp_ready are both high, then the FSM returns to IDLE.
REQ-023 SHALL NOT allow a new accept in the same cycle as response consumption; the earliest next accept is the following cycle.
REQ-024 flush=1 SHALL force IDLE at the next edge from any state, drop any pending or held response, and suppress resp_valid that cycle; flush has priority over accept, countdown and consume.
REQ-025 A flush while req_valid=1 in IDLE SHALL NOT accept the request.
REQ-026 prog_we SHALL write prog_wdata to array[prog_addr] at the clock edge in any state.
REQ-027 When a read and a write hit the same word on the same edge, the read SHALL return the old data.
REQ-028 Address bits above ADDR_WIDTH do not exist; word index bits SHALL wrap naturally.
REQ-029 resp_addr SHALL be the latched request address, unmodified.

Reset
REQ-030 On resetn low, asynchronously: state=IDLE, counter=0, resp_valid=0, resp_instr=0, resp_addr=0, resp_err=0.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 Reset mid-WAIT or mid-RESP SHALL discard the transaction with no response.
REQ-033 req_ready SHALL be 1 from the first cycle after resetn deasserts.

Configuration
REQ-034 With macro IMEM_ALIGN_CHECK_EN defined, a request with req_addr[1:0]!=0 SHALL return resp_err=1 and resp_instr=32'h00000013 (NOP) after the same LATENCY.
REQ-035 With IMEM_ALIGN_CHECK_EN defined, an aligned request SHALL return resp_err=0.
REQ-036 Without IMEM_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored for indexing and resp_err SHALL be tied to 0.

Verification
REQ-037 Basic read: LATENCY=1; prog array[1]=32'h00500093; accept addr 0x004 at cycle N -> resp_valid at N+1, resp_instr=32'h00500093, resp_addr=0x004, resp_err=0.
REQ-038 Latency and backpressure: LATENCY=3, accept at N, resp_ready=0 for 4 cycles -> resp_valid rises at N+3 with outputs stable through the stall; req_ready=0 until the cycle after consumption.
REQ-039 Flush in WAIT: LATENCY=3, flush at N+1 -> no resp_valid ever for that request; req_ready=1 at N+2; a new request to 0x008 returns array[2].
REQ-040 Read/write collision: array[3]=A; prog_we writes B to word 3 on the same edge the read of addr 0x00C occurs -> resp_instr=A; the next read of 0x00C returns B.
REQ-041 Misalign: with IMEM_ALIGN_CHECK_EN defined, request 0x006 -> resp_err=1, resp_instr=32'h00000013; without the macro, the same request -> resp_instr=array[1], resp_err=0.
REQ-042 Reset mid-RESP: resetn low while resp_valid=1 -> resp_valid=0 immediately (asynchronous); after release, req_ready=1 and no stale response is delivered.
